// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// FSM encoding, error codes, default memory size.
package imem_loader_pkg;

  localparam int IM_BYTES_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/be_word_packer.sv
// Big-endian byte-to-word assembler.
// First byte of a group lands in word[31:24].
module be_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        last,
  output logic        word_ready
);

  logic [1:0]  cnt;
  logic [23:0] part;

  // next accepted byte completes the word
  assign last = (cnt == 2'd3);

  // shift bytes in, publish the word on the 4th byte only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 2'd0;
      part       <= 24'd0;
      word       <= 32'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clr) begin
        cnt  <= 2'd0;
        part <= 24'd0;
      end else if (byte_valid) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          word       <= {part, byte_data};
          word_ready <= 1'b1;
        end else begin
          part <= {part[15:0], byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image
// into instruction memory while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int IM_BYTES  = IM_BYTES_DEF,
  parameter  int MAX_WORDS = IM_BYTES / 4,
  localparam int AW        = $clog2(IM_BYTES),
  localparam int IW        = AW - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err
);

  state_t state, state_d;

  logic          run;
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [15:0]   n_new;
  logic [IW-1:0] idx;
  logic [7:0]    csum;

  logic sess_go, hi_we, lo_we, len_bad;
  logic data_take, addr_we, idx_inc;
  logic fin_ok, fin_bad;
  logic pk_last, pk_ready;

  assign n_new = {len_hi, in_data};
  assign busy  = (state != S_IDLE);
  assign im_we = (state == S_WRITE) && pk_ready;

  be_word_packer u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr        (sess_go),
    .byte_valid (data_take),
    .byte_data  (in_data),
    .word       (im_wdata),
    .last       (pk_last),
    .word_ready (pk_ready)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    sess_go   = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    len_bad   = 1'b0;
    data_take = 1'b0;
    addr_we   = 1'b0;
    idx_inc   = 1'b0;
    fin_ok    = 1'b0;
    fin_bad   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && run) begin
          sess_go = 1'b1;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_we   = 1'b1;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lo_we = 1'b1;
          if (n_new == 16'd0 ||
              {1'b0, n_new} > 17'(MAX_WORDS)) begin
            len_bad = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_take = 1'b1;
          if (pk_last) begin
            addr_we = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_inc = 1'b1;
        if (16'(idx) == len - 16'd1) state_d = S_CSUM;
        else                         state_d = S_DATA;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == csum) fin_ok = 1'b1;
          else                 fin_bad = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // release synchroniser, counters, checksum, sticky status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      len_hi   <= 8'd0;
      len      <= 16'd0;
      idx      <= '0;
      csum     <= 8'd0;
      im_addr  <= '0;
      done     <= 1'b0;
      err      <= ERR_NONE;
      cpu_hold <= 1'b0;
    end else begin
      run <= 1'b1;
      if (sess_go) begin
        done     <= 1'b0;
        err      <= ERR_NONE;
        cpu_hold <= 1'b1;
        idx      <= '0;
        csum     <= 8'd0;
      end
      if (hi_we)     len_hi  <= in_data;
      if (lo_we)     len     <= n_new;
      if (len_bad)   err     <= ERR_LEN;
      if (data_take) csum    <= csum + in_data;
      if (addr_we)   im_addr <= {idx, 2'b00};
      if (idx_inc)   idx     <= idx + 1'b1;
      if (fin_ok) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (fin_bad)   err     <= ERR_CSUM;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// Model predicts writes/status from the byte stream.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  n_chk = 0;
  int  n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the queue
  always @(negedge clk) begin
    if (im_we) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h",
                 im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        if (im_addr !== e.addr || im_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write: got %h/%h expected %h/%h",
                   im_addr, im_wdata, e.addr, e.data);
        end
      end
      chk("ready_in_write", in_ready, 0);
    end
  end

  // reference model: derive writes and final status
  task automatic model(input logic [7:0] q[$],
                       output logic xd,
                       output logic [1:0] xe,
                       output logic xh);
    int n;
    logic [7:0] sum;
    wr_t w;
    n = {q[0], q[1]};
    if (n == 0 || n > 256) begin
      xd = 0; xe = 2'b01; xh = 1;
      return;
    end
    sum = 0;
    for (int k = 0; k < n; k++) begin
      w.addr = 10'(k * 4);
      w.data = {q[2+4*k], q[3+4*k], q[4+4*k], q[5+4*k]};
      exp_q.push_back(w);
      for (int b = 0; b < 4; b++) sum = sum + q[2+4*k+b];
    end
    if (q[2+4*n] == sum) begin
      xd = 1; xe = 2'b00; xh = 0;
    end else begin
      xd = 0; xe = 2'b10; xh = 1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("hold_after_start", cpu_hold, 1);
  endtask

  // drive bytes with gaps; optional stray start at byte sp
  task automatic send(input logic [7:0] q[$],
                      input bit tog,
                      input int sp);
    int i = 0;
    int cyc = 0;
    bit v;
    bit sp_done = 0;
    while (i < q.size() && cyc < 6000) begin
      v = tog ? cyc[0] : ($urandom_range(0, 3) != 0);
      in_valid = v;
      in_data  = v ? q[i] : 8'($urandom);
      start    = 1'b0;
      if (!sp_done && sp >= 0 && i == sp) begin
        start   = 1'b1;
        sp_done = 1;
      end
      if (v && in_ready) i++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (cyc >= 6000) chk("send_timeout", 1, 0);
  endtask

  task automatic session(input logic [7:0] q[$],
                         input bit tog,
                         input int sp);
    logic xd, xh;
    logic [1:0] xe;
    int w = 0;
    model(q, xd, xe, xh);
    pulse_start();
    send(q, tog, sp);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("idle", busy, 0);
    chk("done", done, xd);
    chk("err", err, xe);
    chk("cpu_hold", cpu_hold, xh);
    chk("writes_left", exp_q.size(), 0);
    chk("done_err_excl", done && (err != 0), 0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] q[$];
  logic [7:0] s;
  int n;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #23;
    chk_zero("reset");
    release_rst();

    q = '{8'h00, 8'h01, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h54};
    session(q, 0, -1);

    q = '{8'h00, 8'h00};
    session(q, 0, -1);

    q = '{8'h01, 8'h01};
    session(q, 0, -1);

    q = '{8'h00, 8'h02,
          8'h11, 8'h11, 8'h11, 8'h11,
          8'h22, 8'h22, 8'h22, 8'h22, 8'h00};
    session(q, 0, -1);

    q = '{8'h01, 8'h00};
    s = 0;
    for (int i = 0; i < 256; i++) begin
      q.push_back(8'h00); q.push_back(8'h00);
      q.push_back(8'h00); q.push_back(8'(i));
      s = s + 8'(i);
    end
    q.push_back(s);
    session(q, 1, -1);

    q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    pulse_start();
    send(q, 0, -1);
    #2 rst = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    release_rst();
    chk("abort_no_writes", exp_q.size(), 0);
    q = '{8'h00, 8'h01, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h54};
    session(q, 0, -1);

    q = '{8'h00, 8'h02,
          8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    session(q, 0, 4);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 12);
      q = '{8'(n >> 8), 8'(n)};
      s = 0;
      for (int b = 0; b < 4 * n; b++) begin
        q.push_back(8'($urandom));
        s = s + q[q.size()-1];
      end
      if ($urandom_range(0, 1) == 1)
        s = s + 8'($urandom_range(1, 255));
      q.push_back(s);
      session(q, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IM_BYTES, 1024, instruction memory size in bytes; SHALL be a power of two.
REQ-002 Parameter MAX_WORDS, IM_BYTES/4, largest accepted word count.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that opens a load session.
REQ-006 in_valid  input  1  in_data holds a valid stream byte.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 im_we  output  1  instruction-memory word write strobe.
REQ-010 im_addr  output  log2(IM_BYTES)  byte address, word-aligned ([1:0]=0).
REQ-011 im_wdata  output  32  word to write, big-endian (bits [31:24] go to the lowest byte address).
REQ-012 cpu_hold  output  1  keeps the CPU/fetch unit in reset while high.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  sticky: last session completed with no error.
REQ-015 err  output  2  sticky: 00 none, 01 bad length, 10 checksum mismatch.

Function
REQ-016 A byte SHALL transfer only on a rising edge with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-017 Stream format: LEN_HI, LEN_LO (N = {hi,lo} words), 4N payload bytes, 1 checksum byte.
REQ-018 FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM.
REQ-019 IDLE: in_ready=0, busy=0. start → LEN_HI; same edge clears done and err, sets cpu_hold=1 and busy=1.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 LEN_HI/LEN_LO: in_ready=1, one byte each. After LEN_LO, N=0 or N>MAX_WORDS → err=01, IDLE; else → DATA.
REQ-022 DATA: in_ready=1. Bytes fill im_wdata from [31:24] down to [7:0]. The 4th byte moves the FSM to WRITE.
REQ-023 WRITE: lasts exactly one cycle; in_ready=0, im_we=1, im_addr=4*word_idx. Then word_idx increments.
REQ-024 WRITE exit: → CSUM if word_idx was N-1, else → DATA.
REQ-025 The first word SHALL be written to address 0; addresses SHALL never wrap.
REQ-026 Latency: im_we is high in the cycle immediately after the edge that accepts the 4th byte of a word.
REQ-027 Peak throughput: 4 bytes per 5 cycles.
REQ-028 Running checksum: 8-bit modulo-256 sum of the payload bytes only; header and trailer are excluded.
REQ-029 CSUM, trailer equal to the sum: done=1, cpu_hold=0, → IDLE.
REQ-030 CSUM, trailer mismatch: err=10, cpu_hold stays 1, → IDLE.
REQ-031 After any error, cpu_hold SHALL stay 1 until a later session succeeds or reset is applied.
REQ-032 im_we SHALL be 0 outside WRITE. im_addr and im_wdata hold their last values.
REQ-033 done and err SHALL never be nonzero at the same time.

Reset
REQ-034 rst low SHALL immediately force state=IDLE and the following outputs to 0: in_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_hold. Word and byte counters and the checksum also clear to 0.
REQ-035 Reset mid-session SHALL discard any partial word; no im_we is issued.
REQ-036 cpu_hold=0 after reset, so the CPU runs from a preloaded image.
REQ-037 Reset release is synchronised internally; the first state change is allowed at the second rising edge after rst rises.

Structure
REQ-038 Shared package imem_loader_pkg SHALL hold the FSM state enum, the err code constants and the IM_BYTES default.
REQ-039 One sub-module, be_word_packer, SHALL be used. It does byte-to-word big-endian assembly with a 2-bit byte counter and a word-ready flag.

Verification
REQ-040 Stream 00 01 3C 08 00 10 54 → one im_we at addr 0x000 with data 0x3C080010; then done=1, err=00, cpu_hold=0.
REQ-041 Stream 00 00 → err=01, no im_we, cpu_hold=1. Stream 01 01 (N=257, MAX_WORDS=256) → err=01, no im_we.
REQ-042 N=2, words 0x11111111 and 0x22222222, trailer 0x00 (correct sum is 0xCC) → writes at 0x000 and 0x004, then err=10, done=0, cpu_hold=1.
REQ-043 N=256, word i = i, in_valid toggling every cycle → 256 writes, last at 0x3FC with data 0x000000FF, done=1; in_ready=0 in every WRITE cycle.
REQ-044 rst low after 2 payload bytes → all outputs 0 with no clock edge, no im_we. A following full session from REQ-040 succeeds.
REQ-045 start pulsed in DATA → no effect; the session completes normally with done=1.
